irq_pending_arbiter: RTL
========================

Name: irq_pending_arbiter

Overview:
- Upstream front end for the 8:3 priority encoding path.
- Synchronises eight asynchronous interrupt request lines and captures rising edges into a pending register, with a per-bit enable mask.
- Offers the highest-priority enabled pending request (bit 7 highest) as a 3-bit id on a valid/ready handshake.
- Clears the pending bit on acceptance and flags events that arrive while the same bit is already pending.

Parameters:
- N_IRQ, 8, number of request lines; fixed at 8 in this revision.
- ID_W, 3, id width; must equal clog2(N_IRQ).
- LEVEL_MODE, 0, 0 = rising-edge capture, 1 = level capture (pending set every cycle the synced line is high).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous.
- irq_in  in  8  raw asynchronous request lines.
- irq_mask  in  8  1 = line enabled for offer; synchronous to clk.
- irq_valid  out  1  id offered.
- irq_id  out  3  index of offered request.
- irq_ready  in  1  consumer accepts when irq_valid & irq_ready at a rising edge.
- pending  out  8  registered pending vector, masked and unmasked bits.
- overflow  out  1  sticky lost-event flag.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset: s1, s2, s3 sync/history regs = 0; pending = 0; irq_valid = 0; irq_id = 0; overflow = 0; state = IDLE.
- Synchroniser: s1 <= irq_in; s2 <= s1; s3 <= s2.
- Set condition: rise = s2 & ~s3 when LEVEL_MODE = 0; rise = s2 when LEVEL_MODE = 1.
- Latency: line first sampled high at edge N gives s2 = 1 after N+1, pending bit set at N+2, irq_valid = 1 at N+3 when state is IDLE and the bit is enabled.
- Pending update per bit i: pending[i] <= rise[i] | (pending[i] & ~clr[i]). clr[i] = accept & (irq_id == i). Set and clear in the same cycle leave the bit set.
- Overflow: set when rise[i] & pending[i] & ~clr[i] for any i; cleared by ovf_clr. Set wins over ovf_clr in the same cycle.
- FSM IDLE:
  - if |(pending & irq_mask): irq_id <= index of highest set bit of (pending & irq_mask); irq_valid <= 1; go OFFER.
  - Pending bits that are set in this same cycle are not visible until the next cycle.
- FSM OFFER:
  - irq_id and irq_valid hold stable while ~irq_ready, even if a higher-priority request arrives or irq_mask deasserts the offered bit. There is no withdrawal.
  - On accept: pending[irq_id] cleared (subject to set-wins); irq_valid <= 0; go IDLE.
- Throughput: one offer every 2 cycles at most, with a mandatory bubble after each accept.
- Masked bits stay pending indefinitely. They are offered as soon as the mask enables them, with normal priority.
- irq_ready while irq_valid = 0 has no effect.
- Reset mid-operation: irq_valid drops immediately and all pending events are lost. A line held high through reset release registers as one rising edge in edge mode, because s3 = 0.

Decomposition:
- Shared package irq_pkg contains:
  - localparams N_IRQ = 8 and ID_W = 3;
  - state enum {IDLE, OFFER};
  - function onehot index helper.
- One natural sub-module: prio_enc8. It is combinational, 8-bit input, bit 7 highest, with outputs id[2:0] and any. The arbiter instantiates it on pending & irq_mask.

Test Plan:
1. Reset with irq_in = 0, then pulse irq_in[2] high for 3 cycles with irq_ready = 0 -> pending = 8'b0000_0100 at N+2, irq_valid = 1 and irq_id = 3'd2 at N+3, held for 10 cycles. Assert irq_ready for 1 cycle -> irq_valid = 0 and pending = 0 on the next edge.
2. irq_in = 8'b1000_0001 edge in the same cycle, irq_ready = 1 constant -> offers id 7 then id 0, with exactly one idle cycle between the two accepts.
3. Offer id 1 stalled (irq_ready = 0), then raise irq_in[6] -> irq_id stays 1 until accept. The next offer is id 6.
4. irq_mask = 8'h0F and irq_in[5] rises -> pending[5] = 1 and irq_valid stays 0. Set irq_mask = 8'hFF -> irq_id = 5 offered within 1 cycle of the mask change.
5. Bit 3 pending and unaccepted, second rise on irq_in[3] -> overflow = 1 and stays set. Pulse ovf_clr -> overflow = 0. Rise coinciding with accept of id 3 -> pending[3] stays 1 and overflow stays 0.
6. rst_n low asynchronously mid-OFFER (id 4) -> irq_valid = 0 before the next clk edge and pending = 0. Release with irq_in[4] held high -> id 4 re-offered 3 edges later in edge mode. With LEVEL_MODE = 1, id 4 is re-offered after every accept while the line stays high.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending/arbitration path.
package irq_pkg;

   localparam int N_IRQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

   // Converts a one-hot (or all-zero) vector into the index of its set bit.
   function automatic logic [ID_W-1:0] onehot_index(input logic [N_IRQ-1:0] vec);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (vec[i]) begin
            idx = idx | ID_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8:3 priority encoder, bit 7 has the highest priority.
module prio_enc8
   import irq_pkg::*;
(
   input  logic [N_IRQ-1:0] req,
   output logic [ID_W-1:0]  id,
   output logic             any
);

   logic [N_IRQ-1:0] top;
   logic             found;

   // Isolate the highest set request bit, then turn it into its index.
   always_comb begin
      top   = '0;
      found = 1'b0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req[i] && !found) begin
            top[i] = 1'b1;
            found  = 1'b1;
         end
      end
      id  = onehot_index(top);
      any = |req;
   end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Synchronises raw interrupt lines, captures events into a pending register
// and offers the highest-priority enabled pending request on valid/ready.
module irq_pending_arbiter
   import irq_pkg::*;
#(
   parameter bit LEVEL_MODE = 1'b0
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic [N_IRQ-1:0] irq_mask,
   output logic             irq_valid,
   output logic [ID_W-1:0]  irq_id,
   input  logic             irq_ready,
   output logic [N_IRQ-1:0] pending,
   output logic             overflow,
   input  logic             ovf_clr
);

   logic [N_IRQ-1:0] s1;
   logic [N_IRQ-1:0] s2;
   logic [N_IRQ-1:0] s3;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] clr;
   logic [N_IRQ-1:0] eligible;
   logic             accept;
   logic [ID_W-1:0]  enc_id;
   logic             enc_any;
   arb_state_t       state;
   arb_state_t       state_next;
   logic             valid_next;
   logic [ID_W-1:0]  id_next;

   // Two-flop synchroniser plus a history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= irq_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise     = LEVEL_MODE ? s2 : (s2 & ~s3);
   assign accept   = irq_valid & irq_ready;
   assign eligible = pending & irq_mask;

   // One-hot clear of the bit currently being accepted by the consumer.
   always_comb begin
      clr = '0;
      if (accept) begin
         clr = N_IRQ'(1) << irq_id;
      end
   end

   // Pending capture; a new event in the accept cycle keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= rise | (pending & ~clr);
      end
   end

   // Sticky lost-event flag; a fresh loss outranks a clear request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (|(rise & pending & ~clr)) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   prio_enc8 u_prio_enc8 (
      .req (eligible),
      .id  (enc_id),
      .any (enc_any)
   );

   // Offer sequencing: latch an id in IDLE, hold it steady until accepted.
   always_comb begin
      state_next = state;
      valid_next = irq_valid;
      id_next    = irq_id;
      case (state)
         IDLE: begin
            if (enc_any) begin
               id_next    = enc_id;
               valid_next = 1'b1;
               state_next = OFFER;
            end
         end
         OFFER: begin
            if (irq_ready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            valid_next = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   // Offer state and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         irq_valid <= 1'b0;
         irq_id    <= '0;
      end else begin
         state     <= state_next;
         irq_valid <= valid_next;
         irq_id    <= id_next;
      end
   end

endmodule
